// File: rtl/demux_8_128.sv
// Byte demultiplexer: routes data_in to one of 16 registered hold slots with per-channel valid/ack.
// Optional macro DEMUX_AUTO_SEL_EN replaces demux_sel with an internal round-robin sequence counter.
module demux_8_128 (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  demux_sel,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_0,
    output logic [7:0]  data_1,
    output logic [7:0]  data_2,
    output logic [7:0]  data_3,
    output logic [7:0]  data_4,
    output logic [7:0]  data_5,
    output logic [7:0]  data_6,
    output logic [7:0]  data_7,
    output logic [7:0]  data_8,
    output logic [7:0]  data_9,
    output logic [7:0]  data_10,
    output logic [7:0]  data_11,
    output logic [7:0]  data_12,
    output logic [7:0]  data_13,
    output logic [7:0]  data_14,
    output logic [7:0]  data_15,
    output logic [15:0] out_valid,
    input  logic [15:0] out_ack,
    output logic [3:0]  cur_sel
);

    localparam int DATA_W = 8;
    localparam int NCH    = 16;

    logic [DATA_W-1:0] data_q [NCH];
    logic [DATA_W-1:0] data_d [NCH];
    logic [NCH-1:0]    valid_q;
    logic [NCH-1:0]    valid_d;
    logic [3:0]        tgt;
    logic              wr;

`ifdef DEMUX_AUTO_SEL_EN
    logic [3:0] seq_q;
    logic [3:0] seq_d;
    logic       unused_sel;

    assign unused_sel = ^demux_sel;
    assign tgt        = seq_q;

    // Counter only advances on an accepted write, so a stalled slot blocks the rotation.
    always_comb begin
        seq_d = seq_q;
        if (wr) begin
            seq_d = seq_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q <= 4'h0;
        end else begin
            seq_q <= seq_d;
        end
    end
`else
    assign tgt = demux_sel;
`endif

    // A held byte being acked this cycle frees its slot for an immediate rewrite.
    assign in_ready = ~reset & (~valid_q[tgt] | out_ack[tgt]);
    assign wr       = in_valid & in_ready;
    assign cur_sel  = reset ? 4'h0 : tgt;

    always_comb begin
        valid_d = valid_q & ~out_ack;
        for (int n = 0; n < NCH; n++) begin
            data_d[n] = data_q[n];
        end
        if (wr) begin
            data_d[tgt]  = data_in;
            valid_d[tgt] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int n = 0; n < NCH; n++) begin
                data_q[n] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int n = 0; n < NCH; n++) begin
                data_q[n] <= data_d[n];
            end
        end
    end

    assign out_valid = valid_q;
    assign data_0    = data_q[0];
    assign data_1    = data_q[1];
    assign data_2    = data_q[2];
    assign data_3    = data_q[3];
    assign data_4    = data_q[4];
    assign data_5    = data_q[5];
    assign data_6    = data_q[6];
    assign data_7    = data_q[7];
    assign data_8    = data_q[8];
    assign data_9    = data_q[9];
    assign data_10   = data_q[10];
    assign data_11   = data_q[11];
    assign data_12   = data_q[12];
    assign data_13   = data_q[13];
    assign data_14   = data_q[14];
    assign data_15   = data_q[15];

endmodule

// File: tb/tb_demux_8_128.sv
// Directed, table-driven bench for demux_8_128 (default build; auto-select sequences when DEMUX_AUTO_SEL_EN is defined).
module tb_demux_8_128;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  demux_sel;
    logic [7:0]  data_in;
    logic [15:0] out_valid;
    logic [15:0] out_ack;
    logic [3:0]  cur_sel;
    logic [7:0]  d0, d1, d2, d3, d4, d5, d6, d7;
    logic [7:0]  d8, d9, d10, d11, d12, d13, d14, d15;
    logic [7:0]  dout [16];

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        vld;
        logic [3:0]  sel;
        logic [7:0]  din;
        logic [15:0] ack;
        logic        exp_rdy;
        logic [15:0] exp_valid;
        logic [3:0]  ch;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    demux_8_128 dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .demux_sel(demux_sel), .data_in(data_in),
        .data_0(d0), .data_1(d1), .data_2(d2), .data_3(d3),
        .data_4(d4), .data_5(d5), .data_6(d6), .data_7(d7),
        .data_8(d8), .data_9(d9), .data_10(d10), .data_11(d11),
        .data_12(d12), .data_13(d13), .data_14(d14), .data_15(d15),
        .out_valid(out_valid), .out_ack(out_ack), .cur_sel(cur_sel)
    );

    assign dout[0]  = d0;  assign dout[1]  = d1;  assign dout[2]  = d2;  assign dout[3]  = d3;
    assign dout[4]  = d4;  assign dout[5]  = d5;  assign dout[6]  = d6;  assign dout[7]  = d7;
    assign dout[8]  = d8;  assign dout[9]  = d9;  assign dout[10] = d10; assign dout[11] = d11;
    assign dout[12] = d12; assign dout[13] = d13; assign dout[14] = d14; assign dout[15] = d15;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        demux_sel = 4'h0;
        data_in   = 8'h00;
        out_ack   = 16'h0;
        reset     = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'd5,  8'hA5, 16'h0000, 1'b1, 16'h0020, 4'd5,  8'hA5};
        tbl[1]  = '{1'b1, 4'd3,  8'h11, 16'h0000, 1'b1, 16'h0028, 4'd3,  8'h11};
        tbl[2]  = '{1'b1, 4'd3,  8'h22, 16'h0000, 1'b0, 16'h0028, 4'd3,  8'h11};
        tbl[3]  = '{1'b1, 4'd3,  8'h22, 16'h0008, 1'b1, 16'h0028, 4'd3,  8'h22};
        tbl[4]  = '{1'b1, 4'd2,  8'h77, 16'h0000, 1'b1, 16'h002C, 4'd2,  8'h77};
        tbl[5]  = '{1'b1, 4'd7,  8'h99, 16'h0000, 1'b1, 16'h00AC, 4'd7,  8'h99};
        tbl[6]  = '{1'b1, 4'd7,  8'h33, 16'h0084, 1'b1, 16'h00A8, 4'd7,  8'h33};
        tbl[7]  = '{1'b0, 4'd0,  8'hFF, 16'h0020, 1'b1, 16'h0088, 4'd5,  8'hA5};
        tbl[8]  = '{1'b1, 4'd15, 8'hF0, 16'h0000, 1'b1, 16'h8088, 4'd15, 8'hF0};
        tbl[9]  = '{1'b1, 4'd0,  8'h0E, 16'h0001, 1'b1, 16'h8089, 4'd0,  8'h0E};
        tbl[10] = '{1'b1, 4'd8,  8'h5A, 16'hFFFF, 1'b1, 16'h0100, 4'd8,  8'h5A};
        tbl[11] = '{1'b0, 4'd8,  8'h00, 16'h0000, 1'b0, 16'h0100, 4'd8,  8'h5A};

        // Reset state with a write being offered
        in_valid  = 1'b1;
        demux_sel = 4'd6;
        data_in   = 8'hEE;
        out_ack   = 16'h0;
        reset     = 1'b1;
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {16'd0, out_valid}, 32'd0);
        chk("rst_cur_sel", {28'd0, cur_sel}, 32'd0);
        next_cycle();
        chk("rst_hold_valid", {16'd0, out_valid}, 32'd0);
        chk("rst_hold_d6", {24'd0, d6}, 32'd0);
        do_reset();

`ifndef DEMUX_AUTO_SEL_EN
        for (int i = 0; i < 12; i++) begin
            in_valid  = tbl[i].vld;
            demux_sel = tbl[i].sel;
            data_in   = tbl[i].din;
            out_ack   = tbl[i].ack;
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_rdy});
            chk($sformatf("v%0d_cur_sel", i), {28'd0, cur_sel}, {28'd0, tbl[i].sel});
            next_cycle();
            chk($sformatf("v%0d_out_valid", i), {16'd0, out_valid}, {16'd0, tbl[i].exp_valid});
            chk($sformatf("v%0d_data", i), {24'd0, dout[tbl[i].ch]}, {24'd0, tbl[i].exp_data});
            if (i == 0) begin
                for (int n = 0; n < 16; n++) begin
                    if (n != 5) chk($sformatf("v0_other_d%0d", n), {24'd0, dout[n]}, 32'd0);
                end
            end
        end

        // Fill every channel, then reset asynchronously between edges
        do_reset();
        out_ack  = 16'h0;
        in_valid = 1'b1;
        for (int n = 0; n < 16; n++) begin
            demux_sel = n[3:0];
            data_in   = n[7:0];
            next_cycle();
        end
        in_valid = 1'b0;
        chk("fill_out_valid", {16'd0, out_valid}, 32'h0000FFFF);
        chk("fill_d12", {24'd0, d12}, 32'h0C);
        #2;
        reset = 1'b1;
        #1;
        chk("async_out_valid", {16'd0, out_valid}, 32'd0);
        for (int n = 0; n < 16; n++) begin
            chk($sformatf("async_d%0d", n), {24'd0, dout[n]}, 32'd0);
        end
        chk("async_in_ready", {31'd0, in_ready}, 32'd0);
        next_cycle();

        // First write accepted in the first cycle after reset release
        reset     = 1'b0;
        in_valid  = 1'b1;
        demux_sel = 4'd9;
        data_in   = 8'hC3;
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        next_cycle();
        in_valid = 1'b0;
        chk("post_rst_d9", {24'd0, d9}, 32'hC3);
        chk("post_rst_valid", {16'd0, out_valid}, 32'h00000200);
`else
        // Seventeen back-to-back writes, each channel acked the cycle after its write
        in_valid  = 1'b1;
        demux_sel = 4'd0;
        for (int k = 0; k < 17; k++) begin
            data_in = 8'h40 + k[7:0];
            out_ack = (k == 0) ? 16'h0 : (16'h1 << ((k - 1) % 16));
            #1;
            chk($sformatf("rr%0d_cur_sel", k), {28'd0, cur_sel}, k % 16);
            chk($sformatf("rr%0d_ready", k), {31'd0, in_ready}, 32'd1);
            next_cycle();
        end
        in_valid = 1'b0;
        out_ack  = 16'h0;
        for (int n = 1; n < 16; n++) begin
            chk($sformatf("rr_d%0d", n), {24'd0, dout[n]}, 32'h40 + n);
        end
        chk("rr_wrap_d0", {24'd0, d0}, 32'h50);

        // Unacked channel 0 blocks the rotation once it comes round again
        do_reset();
        in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            data_in = 8'h60 + k[7:0];
            next_cycle();
        end
        chk("stall_cur_sel", {28'd0, cur_sel}, 32'd0);
        chk("stall_ready", {31'd0, in_ready}, 32'd0);
        next_cycle();
        chk("stall_hold_d0", {24'd0, d0}, 32'h60);
        chk("stall_hold_sel", {28'd0, cur_sel}, 32'd0);
        out_ack = 16'h0001;
        #1;
        chk("stall_ack_ready", {31'd0, in_ready}, 32'd1);
        next_cycle();
        out_ack  = 16'h0;
        in_valid = 1'b0;
        chk("stall_new_d0", {24'd0, d0}, 32'h6F);
        chk("stall_next_sel", {28'd0, cur_sel}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_8_128.md
DEMUX_8_128 -- requirements
Module: demux_8_128

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits and the channel count at 16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  the write source presents a byte this cycle.
REQ-005 in_ready  output  1  the block accepts the byte this cycle.
REQ-006 demux_sel  input  4  destination channel index 0..15, sampled with in_valid.
REQ-007 data_in  input  8  byte to deliver.
REQ-008 data_0 .. data_15  output  8 each  registered per-channel hold registers.
REQ-009 out_valid  output  16  bit n is set while data_n holds an unread byte.
REQ-010 out_ack  input  16  bit n is the reader's strobe consuming data_n; ignored when out_valid[n]=0.
REQ-011 cur_sel  output  4  channel index the next accepted byte will target.

Function
REQ-012 The target channel t SHALL be demux_sel when DEMUX_AUTO_SEL_EN is undefined, and the internal sequence counter otherwise; cur_sel SHALL always equal t.
REQ-013 in_ready SHALL be combinational and equal to !out_valid[t] | out_ack[t]; it SHALL be 0 during reset.
REQ-014 A write SHALL occur on cycle k when in_valid && in_ready: at edge k, data_t <= data_in and out_valid[t] <= 1.
REQ-015 Latency SHALL be one cycle: the byte is visible on data_t with out_valid[t]=1 in cycle k+1.
REQ-016 For each n, out_ack[n] && out_valid[n] SHALL clear out_valid[n] at the next edge, unless a write to n occurs in the same cycle.
REQ-017 A simultaneous write to and ack of the same channel SHALL leave out_valid[n]=1 with the new byte (the write wins, and the old byte is consumed).
REQ-018 Acks on channels other than t SHALL be processed independently in the same cycle as a write to t.
REQ-019 data_n SHALL hold its value when no write targets n, including after its ack; only out_valid qualifies the byte.
REQ-020 With in_valid=1 and in_ready=0, nothing SHALL change in the datapath and the source SHALL hold data_in and demux_sel stable.
REQ-021 demux_sel SHALL be fully decoded; every 4-bit value maps to a channel, so there is no default or X case.

Reset
REQ-022 While reset=1, the following SHALL hold: data_0..data_15 = 8'h00, out_valid = 16'h0000, the sequence counter = 4'h0, cur_sel = 0 and in_ready = 0.
REQ-023 Reset asserted mid-transfer SHALL discard all held bytes immediately, without waiting for a clock edge.
REQ-024 The first write SHALL be possible in the first cycle with reset=0.

Configuration
REQ-025 With macro DEMUX_AUTO_SEL_EN defined, the following SHALL apply:
- demux_sel is ignored.
- A 4-bit sequence counter selects t.
- The counter increments by 1 on each accepted write and wraps from 15 to 0.
- The counter holds when no write occurs, so a stalled channel blocks all further writes (strict in-order round robin).
REQ-026 With DEMUX_AUTO_SEL_EN undefined, the sequence counter SHALL be absent and t SHALL be demux_sel.

Verification
REQ-027 Reset, then in_valid=1, demux_sel=5, data_in=8'hA5 for one cycle -> next cycle data_5=8'hA5, out_valid=16'h0020, all other data_n=8'h00.
REQ-028 Write 8'h11 to channel 3 with no ack, then present 8'h22 to channel 3 -> in_ready=0 and data_3 stays 8'h11; assert out_ack[3] -> in_ready=1 that cycle, and the next cycle data_3=8'h22 with out_valid[3]=1.
REQ-029 Channel 7 valid; same cycle: write 8'h33 to 7, out_ack[7]=1, out_ack[2]=1 with out_valid[2]=1 -> out_valid[7]=1, data_7=8'h33, out_valid[2]=0.
REQ-030 Fill all 16 channels with bytes 8'h00..8'h0F, then assert reset asynchronously mid-cycle -> out_valid=0 and all data_n=8'h00 before the next edge, and in_ready=0.
REQ-031 With DEMUX_AUTO_SEL_EN defined: 17 back-to-back writes of 8'h40..8'h50, with each channel acked one cycle after its write -> channels 0..15 receive 8'h40..8'h4F, and the 17th byte 8'h50 lands in channel 0 (wrap).
REQ-032 With DEMUX_AUTO_SEL_EN defined: write to channel 0, withhold the ack, and stream 16 further bytes -> cur_sel reaches 0 again, in_ready drops to 0, and it stalls until out_ack[0].
